utm_stepper: RTL
================

Name: utm_stepper

Overview:
- Sequential, parametrised Turing machine core built around the existing one-step transition logic.
- Holds a programmable transition table, an on-chip tape, a head pointer and the machine state.
- Runs autonomously at one transition per clock until it halts, times out or faults.
- Host loads the table and tape, pulses start, then reads back status and tape.

Parameters:
STATE_BITS, 3, width of state encoding (2**STATE_BITS states)
SYM_BITS, 3, width of tape symbol
TAPE_DEPTH, 16, number of tape cells (power of two, >=2)
STEP_BITS, 16, width of step counter and step limit
HALT_STATE, 7, state value that halts the machine

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
prog_we  in  1  write one transition-table entry
prog_addr  in  STATE_BITS+SYM_BITS  entry index {state, symbol}
prog_data  in  STATE_BITS+SYM_BITS+1  entry {next_state, new_sym, dir}; dir 1 = right (+1), 0 = left (-1)
tape_we  in  1  host write to tape
tape_addr  in  log2(TAPE_DEPTH)  host tape address
tape_wdata  in  SYM_BITS  host tape write data
tape_rdata  out  SYM_BITS  tape[tape_addr], combinational, valid at all times
start  in  1  begin a run
start_head  in  log2(TAPE_DEPTH)  initial head position, sampled with start
max_steps  in  STEP_BITS  step limit, sampled with start; 0 = unlimited
busy  out  1  high in RUN
done  out  1  high in DONE
status  out  2  00 none, 01 halted, 10 timeout, 11 head fault
cur_state  out  STATE_BITS  current machine state
head_pos  out  log2(TAPE_DEPTH)  current head position
step_count  out  STEP_BITS  transitions executed in the current run

Behaviour:
- Reset: rst_n is sampled only at a clk edge (synchronous, active-low).
  - After that edge: FSM = IDLE, busy=0, done=0, status=00, cur_state=0, head_pos=0, step_count=0.
  - Table and tape arrays are not reset; contents are retained through rst_n.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, host access:
  - prog_we writes table[prog_addr].
  - tape_we writes tape[tape_addr].
  - Both may occur in the same cycle.
- IDLE or DONE, start=1:
  - Next edge loads cur_state=0, head_pos=start_head, step_count=0, status=00, latched limit=max_steps.
  - FSM -> RUN; busy=1, done=0.
  - Host writes in that same cycle are still performed.
- RUN, one decision per edge, in this priority order:
  1. cur_state==HALT_STATE -> DONE, status=01.
  2. Latched limit!=0 and step_count==limit -> DONE, status=10.
  3. Otherwise execute one step with e = table[{cur_state, tape[head_pos]}]:
     - tape[head_pos] <= e.new_sym;
     - cur_state <= e.next_state;
     - step_count += 1, saturating at all-ones;
     - if dir=1 and head_pos==TAPE_DEPTH-1, or dir=0 and head_pos==0: head_pos unchanged, FSM -> DONE, status=11 (write and state update still performed);
     - else head_pos <= head_pos ± 1 and FSM stays in RUN.
- In RUN, prog_we, tape_we and start are ignored. tape_rdata remains readable and reflects in-run writes.
- DONE holds all outputs until the next start or reset.
- Halting in HALT_STATE at run start (table not consulted) -> DONE after 1 cycle, step_count=0.
- Latency: a run of N executed steps ending in halt keeps busy high for N+1 cycles.
- Reset mid-RUN: next edge returns to the reset values above. Tape writes already committed remain.
- Unprogrammed table entries hold undefined content; the bench must program every entry it reaches.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with start=1 -> busy=0, done=0, status=00, cur_state=0, head_pos=0, step_count=0, and no run begins.
- Halt run:
  - Program: table[{0,0}]={0,1,right}; table[{0,1}]={7,1,right}.
  - Tape: cells 0-3 =0, cell 4 =1, others 0; start_head=0, max_steps=0.
  - Required: busy high exactly 6 cycles, then done=1, status=01, step_count=5, cur_state=7, head_pos=5, tape_rdata of cells 0-4 = 1.
- Timeout: same program and tape, max_steps=3 -> status=10, step_count=3, cur_state=0, head_pos=3, cells 0-2 = 1, cell 3 = 0.
- Right fault: tape all 0, start_head=15 -> after 1 step: status=11, tape[15]=1, head_pos=15, step_count=1, cur_state=0.
- Left fault: table[{0,0}]={2,5,left}, start_head=0 -> status=11, tape[0]=5, cur_state=2, head_pos=0, step_count=1.
- Ignored accesses and mid-run reset:
  - During RUN, pulse tape_we to cell 9 with data 6, pulse prog_we, and assert start -> tape[9] unchanged, table unchanged, run completes normally.
  - Drop rst_n after 2 halt-run steps -> next edge IDLE with reset values; cells 0-1 read 1.

Source files
------------

// File: rtl/utm_stepper_if.sv
// Host-side bus of the Turing machine stepper: table/tape programming, run control and status.
interface utm_stepper_if #(
  parameter int unsigned STATE_BITS = 3,
  parameter int unsigned SYM_BITS   = 3,
  parameter int unsigned TAPE_DEPTH = 16,
  parameter int unsigned STEP_BITS  = 16
);
  localparam int unsigned AW    = $clog2(TAPE_DEPTH);
  localparam int unsigned IDX_W = STATE_BITS + SYM_BITS;
  localparam int unsigned ENT_W = IDX_W + 1;

  logic                  prog_we;
  logic [IDX_W-1:0]      prog_addr;
  logic [ENT_W-1:0]      prog_data;
  logic                  tape_we;
  logic [AW-1:0]         tape_addr;
  logic [SYM_BITS-1:0]   tape_wdata;
  logic [SYM_BITS-1:0]   tape_rdata;
  logic                  start;
  logic [AW-1:0]         start_head;
  logic [STEP_BITS-1:0]  max_steps;
  logic                  busy;
  logic                  done;
  logic [1:0]            status;
  logic [STATE_BITS-1:0] cur_state;
  logic [AW-1:0]         head_pos;
  logic [STEP_BITS-1:0]  step_count;

  modport master (
    output prog_we, prog_addr, prog_data, tape_we, tape_addr, tape_wdata,
           start, start_head, max_steps,
    input  tape_rdata, busy, done, status, cur_state, head_pos, step_count
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, tape_we, tape_addr, tape_wdata,
           start, start_head, max_steps,
    output tape_rdata, busy, done, status, cur_state, head_pos, step_count
  );
endinterface

// File: rtl/utm_stepper.sv
// Sequential Turing machine core: programmable transition table and on-chip tape,
// one transition per clock until halt, step-limit timeout or head fault.
module utm_stepper #(
  parameter int unsigned STATE_BITS = 3,
  parameter int unsigned SYM_BITS   = 3,
  parameter int unsigned TAPE_DEPTH = 16,
  parameter int unsigned STEP_BITS  = 16,
  parameter int unsigned HALT_STATE = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  utm_stepper_if.slave  bus
);
  localparam int unsigned AW        = $clog2(TAPE_DEPTH);
  localparam int unsigned IDX_W     = STATE_BITS + SYM_BITS;
  localparam int unsigned TBL_DEPTH = 2 ** IDX_W;

  localparam logic [1:0] STAT_NONE    = 2'b00;
  localparam logic [1:0] STAT_HALTED  = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;
  localparam logic [1:0] STAT_FAULT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  typedef struct packed {
    logic [STATE_BITS-1:0] next_state;
    logic [SYM_BITS-1:0]   new_sym;
    logic                  dir;
  } entry_t;

  fsm_e                  state_q, state_d;
  logic [STATE_BITS-1:0] cur_state_q, cur_state_d;
  logic [AW-1:0]         head_q, head_d;
  logic [STEP_BITS-1:0]  step_q, step_d;
  logic [STEP_BITS-1:0]  limit_q, limit_d;
  logic [1:0]            status_q, status_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  entry_t                tbl_q  [TBL_DEPTH];
  logic [SYM_BITS-1:0]   tape_q [TAPE_DEPTH];

  logic                  tbl_we_c;
  logic                  tape_we_c;
  logic [AW-1:0]         tape_waddr_c;
  logic [SYM_BITS-1:0]   tape_wdata_c;
  logic [SYM_BITS-1:0]   rd_sym_c;
  entry_t                ent_c;
  logic                  at_edge_c;

  assign rd_sym_c  = tape_q[head_q];
  assign ent_c     = tbl_q[{cur_state_q, rd_sym_c}];
  assign at_edge_c = ent_c.dir ? (head_q == AW'(TAPE_DEPTH - 1)) : (head_q == '0);

  // Next-state and memory write control
  always_comb begin
    state_d      = state_q;
    cur_state_d  = cur_state_q;
    head_d       = head_q;
    step_d       = step_q;
    limit_d      = limit_q;
    status_d     = status_q;
    busy_d       = busy_q;
    done_d       = done_q;
    tbl_we_c     = 1'b0;
    tape_we_c    = 1'b0;
    tape_waddr_c = bus.tape_addr;
    tape_wdata_c = bus.tape_wdata;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        tbl_we_c  = bus.prog_we;
        tape_we_c = bus.tape_we;
        if (bus.start) begin
          state_d     = ST_RUN;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          cur_state_d = '0;
          head_d      = bus.start_head;
          step_d      = '0;
          status_d    = STAT_NONE;
          limit_d     = bus.max_steps;
        end
      end
      ST_RUN: begin
        if (cur_state_q == STATE_BITS'(HALT_STATE)) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          status_d = STAT_HALTED;
        end else if ((limit_q != '0) && (step_q == limit_q)) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          status_d = STAT_TIMEOUT;
        end else begin
          tape_we_c    = 1'b1;
          tape_waddr_c = head_q;
          tape_wdata_c = ent_c.new_sym;
          cur_state_d  = ent_c.next_state;
          step_d       = (&step_q) ? step_q : step_q + STEP_BITS'(1);
          // Falling off the tape still commits the write and state update
          if (at_edge_c) begin
            state_d  = ST_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            status_d = STAT_FAULT;
          end else begin
            head_d = ent_c.dir ? head_q + AW'(1) : head_q - AW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_state_q <= '0;
      head_q      <= '0;
      step_q      <= '0;
      limit_q     <= '0;
      status_q    <= STAT_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_state_q <= cur_state_d;
      head_q      <= head_d;
      step_q      <= step_d;
      limit_q     <= limit_d;
      status_q    <= status_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Table and tape are not cleared by reset; a reset edge suppresses any write
  always_ff @(posedge clk) begin
    if (rst_n && tbl_we_c) begin
      tbl_q[bus.prog_addr] <= entry_t'(bus.prog_data);
    end
    if (rst_n && tape_we_c) begin
      tape_q[tape_waddr_c] <= tape_wdata_c;
    end
  end

  assign bus.tape_rdata = tape_q[bus.tape_addr];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.status     = status_q;
  assign bus.cur_state  = cur_state_q;
  assign bus.head_pos   = head_q;
  assign bus.step_count = step_q;
endmodule
